sdf_fft_frame_ctrl: RTL and testbench

Frame-level sequencer placed in front of and behind the 10-stage SDF FFT pipeline. It gates an upstream valid/ready sample stream into DATA_NUM-sample frames and drives the pipeline's enable and data inputs. It also zero-pads partial frames and injects zero "drain" frames so the last real frame is pushed out of the pipeline. On the output side it tags results as real or drain, discards drain results, and marks frame start, frame end and bin index.

---
 rtl/sdf_fft_pkg.sv | 35 +++
 rtl/sdf_fft_frame_ctrl_tag_fifo.sv | 62 ++++++
 rtl/sdf_fft_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sdf_fft_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_fft_pkg.sv
// sdf_fft_pkg
// Shared definitions for the SDF FFT frame controller:
//   - frame_state_e : input-side sequencer states
//   - log2n()       : index width derivation for an N-point frame
//   - TAG_REAL / TAG_DRAIN : tag values carried alongside each in-flight frame
//   - bit_reverse() : reverses the low 'width' bits of a value
package sdf_fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no partial frame
        ST_FILL  = 2'd1,  // partial frame, accepting upstream samples
        ST_PAD   = 2'd2,  // zero-filling the rest of a partial frame
        ST_DRAIN = 2'd3   // injecting whole zero frames
    } frame_state_e;

    localparam logic TAG_REAL  = 1'b1;
    localparam logic TAG_DRAIN = 1'b0;

    function automatic int log2n(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits at or above 'width' come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = v[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_fft_frame_ctrl_tag_fifo.sv
// sdf_fft_tag_fifo
// 1-bit synchronous FIFO holding one tag per frame in flight through the FFT
// pipeline. A push and a pop in the same cycle are both honoured (a push into a
// full FIFO is accepted only when a pop frees the slot in the same cycle).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   push, push_tag     : write request and tag value
//   pop                : remove the head entry (ignored when empty)
//   full, empty        : occupancy flags
//   head_tag           : tag at the head (valid when !empty)
//   ones_cnt           : number of TAG_REAL entries currently stored
module sdf_fft_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_tag,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == CNT_W'(DEPTH));
    assign empty    = (occ == '0);
    assign head_tag = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            ones_cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            occ      <= occ + CNT_W'(do_push) - CNT_W'(do_pop);
            ones_cnt <= ones_cnt + CNT_W'(do_push & push_tag) - CNT_W'(do_pop & head_tag);
        end
    end

endmodule

// File: rtl/sdf_fft_frame_ctrl.sv
// sdf_fft_frame_ctrl
// Frame sequencer around a DATA_NUM-point SDF FFT pipeline. Input side: gates a
// valid/ready sample stream into frames, zero-pads partial frames (on flush or
// idle timeout) and injects zero drain frames until every real frame has left
// the pipeline. Output side: tags results real/drain, drops drain results and
// marks frame start/end and bin index.
//
// Handshake: a sample transfers on a rising edge where s_valid & s_ready are both
// high; s_ready never depends on s_valid. The output side cannot be stalled.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s_valid, s_ready, s_data  : upstream sample stream
//   flush                     : pulse, finish current frame and drain real results
//   fft_en, fft_data          : pipeline input (one register stage after acceptance)
//   fft_o_en, fft_o_data      : pipeline output
//   m_valid, m_data           : real results (one register stage)
//   m_sof, m_eof, m_bin       : frame start/end, bin index of m_data
//   busy                      : sequencer active or frames still in flight
//   err_unexp                 : sticky, pipeline output seen with no frame in flight
//
// Build option: define SDF_FFT_FRAME_CTRL_BITREV_EN to report m_bin as the
// bit-reversed arrival index (natural frequency bin); otherwise m_bin is the raw
// arrival index.
module sdf_fft_frame_ctrl
    import sdf_fft_pkg::*;
#(
    parameter int DATA_NUM     = 1024,
    parameter int DATA_WIDTH   = 64,
    parameter int IDLE_TIMEOUT = 16,
    parameter int MAX_INFLIGHT = 4,
    localparam int LOG2N       = log2n(DATA_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  flush,
    output logic                  fft_en,
    output logic [DATA_WIDTH-1:0] fft_data,
    input  logic                  fft_o_en,
    input  logic [DATA_WIDTH-1:0] fft_o_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic [LOG2N-1:0]      m_bin,
    output logic                  busy,
    output logic                  err_unexp
);

    localparam int               TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int               CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [LOG2N-1:0] LAST  = LOG2N'(DATA_NUM - 1);

    frame_state_e           state;
    frame_state_e           state_nxt;
    logic [LOG2N-1:0]       in_cnt;
    logic [LOG2N-1:0]       out_cnt;
    logic [TMR_W-1:0]       idle_cnt;

    logic                   in_open;
    logic                   accept;
    logic                   timeout;
    logic                   frame_last;
    logic                   real_pending;
    logic                   issue;
    logic [DATA_WIDTH-1:0]  issue_data;
    logic                   issue_tag;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   head_tag;
    logic [CNT_W-1:0]       real_cnt;
    logic                   out_take;
    logic                   out_real;
    logic                   pop;
    logic [LOG2N-1:0]       bin_idx;

    // ---------------- input side ----------------
    assign in_open    = (state == ST_IDLE) || (state == ST_FILL);
    // A new frame may only start when there is a tag slot for it.
    assign s_ready    = in_open & ~rst & ~((in_cnt == '0) & fifo_full);
    assign accept     = s_valid & s_ready;
    assign frame_last = (in_cnt == LAST);
    assign real_pending = (real_cnt != '0);
    // The timer only advances while upstream is offered a slot and declines it;
    // cycles where the controller itself withholds s_ready are not idleness.
    assign timeout    = in_open & s_ready & ~s_valid & (idle_cnt == TMR_W'(IDLE_TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_data = '0;
        issue_tag  = TAG_REAL;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    issue      = 1'b1;
                    issue_data = s_data;
                    state_nxt  = flush ? ST_PAD : ST_FILL;
                end else if ((flush | timeout) & real_pending) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    issue      = 1'b1;
                    issue_data = s_data;
                    if (frame_last) begin
                        state_nxt = flush ? ST_DRAIN : ST_IDLE;
                    end else if (flush) begin
                        state_nxt = ST_PAD;
                    end
                end else if (flush | timeout) begin
                    state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                issue = 1'b1;
                // The padded frame is itself real, so drain always follows it.
                if (frame_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                issue_tag = TAG_DRAIN;
                if (in_cnt != '0) begin
                    issue = 1'b1;
                end else if (!real_pending) begin
                    state_nxt = ST_IDLE;
                end else if (!fifo_full) begin
                    issue = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            in_cnt   <= '0;
            idle_cnt <= '0;
            fft_en   <= 1'b0;
            fft_data <= '0;
        end else begin
            state    <= state_nxt;
            fft_en   <= issue;
            fft_data <= issue_data;
            if (issue) begin
                in_cnt <= in_cnt + LOG2N'(1);
            end
            if (!in_open || accept) begin
                idle_cnt <= '0;
            end else if (s_ready && !s_valid && idle_cnt != TMR_W'(IDLE_TIMEOUT - 1)) begin
                idle_cnt <= idle_cnt + TMR_W'(1);
            end
        end
    end

    sdf_fft_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue & frame_last),
        .push_tag (issue_tag),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_tag (head_tag),
        .ones_cnt (real_cnt)
    );

    // ---------------- output side ----------------
    assign out_take = fft_o_en & ~fifo_empty;
    assign out_real = out_take & (head_tag == TAG_REAL);
    assign pop      = out_take & (out_cnt == LAST);
    assign busy     = (state != ST_IDLE) | ~fifo_empty;

`ifdef SDF_FFT_FRAME_CTRL_BITREV_EN
    assign bin_idx = LOG2N'(bit_reverse(32'(out_cnt), LOG2N));
`else
    assign bin_idx = out_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            m_bin     <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (out_take) begin
                out_cnt <= out_cnt + LOG2N'(1);
            end
            m_valid <= out_real;
            m_data  <= out_real ? fft_o_data : '0;
            m_sof   <= out_real & (out_cnt == '0);
            m_eof   <= out_real & (out_cnt == LAST);
            m_bin   <= out_real ? bin_idx : '0;
            if (fft_o_en && fifo_empty) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdf_fft_frame_ctrl.sv
`timescale 1ns/1ps
module tb_sdf_fft_frame_ctrl;
  localparam int N   = 16;
  localparam int W   = 32;
  localparam int LB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          flush = 1'b0;
  logic          fft_en;
  logic [W-1:0]  fft_data;
  logic          fft_o_en;
  logic [W-1:0]  fft_o_data;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_sof;
  logic          m_eof;
  logic [LB-1:0] m_bin;
  logic          busy;
  logic          err_unexp;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [6:0] tap = 7'd19;
  logic oen_force = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] in_d[$];
  int           in_t[$];
  logic [W-1:0] out_d[$];
  logic         out_sof[$];
  logic         out_eof[$];
  logic [LB-1:0] out_bin[$];

`ifdef SDF_FFT_FRAME_CTRL_BITREV_EN
  int bin_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
  int bin_tab [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  sdf_fft_frame_ctrl #(
    .DATA_NUM(N), .DATA_WIDTH(W), .IDLE_TIMEOUT(4), .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .fft_en(fft_en), .fft_data(fft_data), .fft_o_en(fft_o_en),
    .fft_o_data(fft_o_data), .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof),
    .m_eof(m_eof), .m_bin(m_bin), .busy(busy), .err_unexp(err_unexp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pipeline model: pure delay line ----------------
  logic         en_line [128];
  logic [W-1:0] d_line  [128];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        en_line[i] <= 1'b0;
        d_line[i]  <= '0;
      end
    end else begin
      en_line[0] <= fft_en;
      d_line[0]  <= fft_data;
      for (int i = 1; i < 128; i++) begin
        en_line[i] <= en_line[i-1];
        d_line[i]  <= d_line[i-1];
      end
    end
  end
  assign fft_o_en   = en_line[tap] | oen_force;
  assign fft_o_data = d_line[tap];

  // ---------------- capture ----------------
  always @(negedge clk) begin
    if (fft_en === 1'b1) begin
      in_d.push_back(fft_data);
      in_t.push_back(cyc);
    end
    if (m_valid === 1'b1) begin
      out_d.push_back(m_data);
      out_sof.push_back(m_sof);
      out_eof.push_back(m_eof);
      out_bin.push_back(m_bin);
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int latency);
    tap = 7'(latency - 1);
    rst = 1'b1;
    s_valid = 1'b0;
    flush = 1'b0;
    oen_force = 1'b0;
    repeat (3) tick();
    check("rst_s_ready_low", s_ready, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    check("send_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    check(tag, busy, 0);
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input int base, input int nreal);
    logic [W-1:0] e;
    check({tag, "_out_count"}, out_d.size() - base, nreal);
    for (int i = 0; i < nreal; i++) begin
      e = exp_q.pop_front();
      if (base + i < out_d.size()) begin
        check({tag, "_data"}, out_d[base+i], e);
        check({tag, "_sof"}, out_sof[base+i], (i % N) == 0);
        check({tag, "_eof"}, out_eof[base+i], (i % N) == N - 1);
        check({tag, "_bin"}, out_bin[base+i], bin_tab[i % N]);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_drain_in(input string tag, input int base, input int nreal_in);
    int n_in;
    int nz;
    n_in = in_d.size() - base;
    check({tag, "_in_whole_frames"}, n_in % N, 0);
    check({tag, "_in_has_drain"}, n_in >= nreal_in + N, 1);
    nz = 0;
    for (int i = base + nreal_in; i < in_d.size(); i++) if (in_d[i] != '0) nz++;
    check({tag, "_drain_zero"}, nz, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bi;
    int bo;
    int acc;
    logic rec;

    // Reset values
    do_reset(20);
    check("reset_s_ready", s_ready, 1);
    check("reset_fft_en", fft_en, 0);
    check("reset_fft_data", fft_data, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_sof", m_sof, 0);
    check("reset_m_eof", m_eof, 0);
    check("reset_m_bin", m_bin, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err_unexp, 0);

    // Two back-to-back frames 0..31 then idle: drain follows automatically
    bi = in_d.size();
    bo = out_d.size();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(W'(i));
      send(W'(i));
    end
    check("t1_busy_after_frames", busy, 1);
    wait_idle("t1_idle", 800);
    for (int i = 0; i < 32; i++)
      if (bi + i < in_d.size()) check("t1_in_data", in_d[bi+i], i);
    check("t1_in_contig", in_t[bi+31] - in_t[bi], 31);
    check_drain_in("t1", bi, 32);
    check_out("t1", bo, 32);

    // 5 samples then flush: 11 pad zeros, drain frame(s), 16 real outputs
    do_reset(20);
    bi = in_d.size();
    bo = out_d.size();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(W'(i));
      send(W'(i));
    end
    for (int i = 0; i < 11; i++) exp_q.push_back('0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_pad_s_ready", s_ready, 0);
    check("t2_pad_busy", busy, 1);
    wait_idle("t2_idle", 800);
    for (int i = 0; i < 16; i++)
      if (bi + i < in_d.size()) check("t2_in_data", in_d[bi+i], (i < 5) ? i + 1 : 0);
    check("t2_pad_contig", in_t[bi+15] - in_t[bi+5], 10);
    check("t2_pad_start", in_t[bi+5] - in_t[bi+4], 2);
    check_drain_in("t2", bi, 16);
    check_out("t2", bo, 16);

    // 10 samples then s_valid low: timeout after 4 idle cycles enters PAD
    do_reset(20);
    bi = in_d.size();
    bo = out_d.size();
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(W'(i));
      send(W'(i));
    end
    for (int i = 0; i < 6; i++) exp_q.push_back('0);
    repeat (3) tick();
    check("t3_no_early_timeout", s_ready, 1);
    wait_idle("t3_idle", 800);
    check("t3_timeout_gap", in_t[bi+10] - in_t[bi+9], 5);
    check("t3_pad_contig", in_t[bi+15] - in_t[bi+10], 5);
    for (int i = 0; i < 16; i++)
      if (bi + i < in_d.size()) check("t3_in_data", in_d[bi+i], (i < 10) ? i + 1 : 0);
    check_drain_in("t3", bi, 16);
    check_out("t3", bo, 16);

    // Long pipeline latency: FIFO fills, s_ready stalls at a frame boundary
    do_reset(100);
    bo = out_d.size();
    acc = 0;
    rec = 1'b0;
    for (int k = 0; k < 80; k++) begin
      s_valid = 1'b1;
      s_data = W'(acc + 1);
      if (s_ready) begin
        exp_q.push_back(W'(acc + 1));
        acc++;
      end
      tick();
    end
    check("t4_accepted_before_stall", acc, 64);
    check("t4_stalled", s_ready, 0);
    check("t4_no_output_yet", out_d.size() - bo, 0);
    for (int k = 0; k < 300 && acc < 80; k++) begin
      s_valid = 1'b1;
      s_data = W'(acc + 1);
      if (s_ready) begin
        if (!rec) begin
          rec = 1'b1;
          check("t4_recover_on_pop_eof", m_eof, 1);
          check("t4_recover_after_frame", out_d.size() - bo, 15);
        end
        exp_q.push_back(W'(acc + 1));
        acc++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("t4_recovered", rec, 1);
    check("t4_accepted_total", acc, 80);
    wait_idle("t4_idle", 3000);
    check_out("t4", bo, 80);

    // Reset mid-frame: partial frame discarded, no outputs follow
    do_reset(20);
    bo = out_d.size();
    for (int i = 1; i <= 7; i++) send(W'(i + 40));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_busy_after_rst", busy, 0);
    repeat (60) tick();
    check("t6_no_outputs", out_d.size() - bo, 0);
    check("t6_still_idle", busy, 0);

    // Unexpected pipeline output with empty tag FIFO
    do_reset(20);
    oen_force = 1'b1;
    tick();
    oen_force = 1'b0;
    check("t5_err_set", err_unexp, 1);
    check("t5_m_valid_low", m_valid, 0);
    repeat (3) tick();
    check("t5_err_sticky", err_unexp, 1);
    check("t5_m_valid_stays_low", m_valid, 0);
    rst = 1'b1;
    tick();
    check("t5_err_cleared", err_unexp, 0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
